instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Initiator side of the instruction-memory interface: owns the program counter, drives `imem_req`/`imem_addr`, captures the combinational `imem_data` return in the same cycle, and buffers fetched words in a small FIFO toward decode with a valid/ready handshake. It handles control-flow redirects from execute and flags misaligned or out-of-range fetch addresses. It sits between the instruction memory and the decode stage.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `MEM_BYTES`, 128, instruction memory size in bytes; a fetch with `pc + 3 >= MEM_BYTES` is out of range.
- `FIFO_DEPTH`, 2, fetch buffer entries (>= 1).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `fetch_en`  in  1  fetch permission; when low, no new requests are issued and the FIFO still drains.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  byte address; equals `pc`.
- `imem_data`  in  32  instruction word returned combinationally in the same cycle as `imem_req`.
- `redirect_valid`  in  1  branch/jump redirect strobe.
- `redirect_pc`  in  32  redirect target.
- `if_valid`  out  1  FIFO head valid toward decode.
- `if_ready`  in  1  decode accepts head.
- `if_instr`  out  32  head instruction word.
- `if_pc`  out  32  head instruction address.
- `fetch_fault`  out  1  fault state indicator.
- `fault_pc`  out  32  offending address.

## Operation
- States: IDLE, FETCH, FAULT.
- Reset: state=IDLE, pc=`RESET_PC`, FIFO empty, `if_valid`=0, `imem_req`=0, `if_instr`/`if_pc`=0, `fetch_fault`=0, `fault_pc`=0.
- `pop` = `if_valid && if_ready`. `if_valid` = (count != 0) && !`redirect_valid`.
- `pc_bad` = `pc[1:0] != 0` or `pc + 3 >= MEM_BYTES`, with the comparison done in 33 bits and no wrap.
- `imem_req` = state==FETCH && `fetch_en` && !`redirect_valid` && !`pc_bad` && (count < `FIFO_DEPTH` || `pop`).
- When `imem_req`=1, push {pc, `imem_data`} into the FIFO and set pc <= pc+4 in the same edge. `imem_data` is word-as-returned; no byte swap.
- Simultaneous push and pop when full is allowed, so throughput is 1 word/cycle.
- Redirect has the highest priority, in every state:
  - flush the FIFO (count <= 0) and set pc <= `redirect_pc`;
  - no request and no pop in that cycle;
  - next state is FETCH if `fetch_en`, else IDLE;
  - `fetch_fault` <= 0.
- A faulting target is caught on the next FETCH cycle through `pc_bad`.
- Transitions from IDLE: go to FETCH when `fetch_en`=1.
- Transitions from FETCH:
  - `fetch_en`=0 -> IDLE, no request;
  - `pc_bad` -> FAULT, `fault_pc` <= pc, `fetch_fault` <= 1, no request, pc holds.
- Transitions from FAULT: hold, with no requests, until a redirect occurs. Already-buffered entries still drain to decode.
- Reset asserted mid-operation: immediate return to reset values. In-flight FIFO contents are lost.

## Timing
- Fetch latency: a request in cycle N makes the word visible as `if_valid` at N+1 if the FIFO was empty.
- Redirect in cycle N: `imem_req` to the target in N+1, `if_valid` with the target word in N+2.
- A misaligned or out-of-range target redirected in N: `fetch_fault`=1 from N+2.
- `imem_addr` is driven from the pc register and is stable for the whole cycle. `imem_req` depends combinationally on `if_ready`, `redirect_valid`, `fetch_en`.
- FIFO outputs (`if_instr`, `if_pc`) are driven from the head register and are stable while `if_valid` && !`if_ready`.

## Test plan
- Streaming:
  - stimulus: memory words 0x00500093, 0x00100113, 0x002081B3 at addresses 0/4/8, `fetch_en`=1, `if_ready`=1;
  - required response: `imem_addr` 0,4,8 on consecutive cycles; `if_instr`/`if_pc` pairs (0x00500093,0), (0x00100113,4), (0x002081B3,8) on consecutive cycles from cycle 1; one word/cycle.
- Backpressure:
  - stimulus: `if_ready`=0 for 5 cycles;
  - required response: exactly 2 pushes, then `imem_req`=0; the head stays 0x00500093/pc 0. After `if_ready`=1, the sequence resumes with no loss or duplication.
- Redirect:
  - stimulus: `redirect_valid` with `redirect_pc`=0x40 while the FIFO holds 2 entries;
  - required response: `if_valid`=0 in that cycle; `imem_addr`=0x40 the next cycle; the first `if_pc` after the flush is 0x40.
- Misaligned redirect:
  - stimulus: `redirect_pc`=0x22;
  - required response: no `imem_req` afterward; `fetch_fault`=1 and `fault_pc`=0x22 two cycles later. A later redirect to 0x10 clears `fetch_fault` and fetch resumes at 0x10.
- Out of range:
  - stimulus: sequential fetch reaching pc=0x80 with `MEM_BYTES`=128;
  - required response: the last request is at 0x7C, then FAULT with `fault_pc`=0x80; the buffered 0x7C word still drains.
- Async reset:
  - stimulus: `rst_n` low mid-stream, between clock edges;
  - required response: `imem_req`, `if_valid` and `fetch_fault` go to 0 immediately. After release with `fetch_en`=1, the first request is at `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues single-cycle fetches to instruction
// memory and buffers {pc, word} pairs in a small shift FIFO toward decode.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_BYTES  = 128,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [31:0]      pc_r;
  logic [31:0]      pc_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic [CNT_W-1:0] wr_idx_s;
  logic [31:0]      fifo_pc_r     [FIFO_DEPTH];
  logic [31:0]      fifo_instr_r  [FIFO_DEPTH];
  logic [31:0]      fifo_pc_nxt_s [FIFO_DEPTH];
  logic [31:0]      fifo_instr_nxt_s [FIFO_DEPTH];
  logic             fault_r;
  logic             fault_nxt_s;
  logic [31:0]      fault_pc_r;
  logic [31:0]      fault_pc_nxt_s;
  logic [32:0]      pc_end_s;
  logic             pc_bad_s;
  logic             full_s;
  logic             if_valid_s;
  logic             pop_s;
  logic             push_s;

  // Handshake, fault detection and request qualification.
  always_comb begin
    pc_end_s   = {1'b0, pc_r} + 33'd3;
    pc_bad_s   = (pc_r[1:0] != 2'b00) || (pc_end_s >= 33'(MEM_BYTES));
    full_s     = (count_r >= CNT_W'(FIFO_DEPTH));
    if_valid_s = (count_r != {CNT_W{1'b0}}) && !redirect_valid;
    pop_s      = if_valid_s && if_ready;
    push_s     = (state_r == FETCH) && fetch_en && !redirect_valid && !pc_bad_s &&
                 (!full_s || pop_s);
  end

  // FIFO next state: entry 0 is always the head; a pop shifts, a push lands behind the survivors.
  always_comb begin
    wr_idx_s    = count_r - CNT_W'(pop_s);
    count_nxt_s = redirect_valid ? {CNT_W{1'b0}}
                                 : (count_r + CNT_W'(push_s) - CNT_W'(pop_s));
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (push_s && (CNT_W'(i) == wr_idx_s)) begin
        fifo_pc_nxt_s[i]    = pc_r;
        fifo_instr_nxt_s[i] = imem_data;
      end else if (pop_s) begin
        fifo_pc_nxt_s[i]    = fifo_pc_r[(i < FIFO_DEPTH - 1) ? i + 1 : i];
        fifo_instr_nxt_s[i] = fifo_instr_r[(i < FIFO_DEPTH - 1) ? i + 1 : i];
      end else begin
        fifo_pc_nxt_s[i]    = fifo_pc_r[i];
        fifo_instr_nxt_s[i] = fifo_instr_r[i];
      end
    end
  end

  // Control FSM; a redirect overrides every state and clears the fault flag.
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    fault_nxt_s    = fault_r;
    fault_pc_nxt_s = fault_pc_r;
    if (redirect_valid) begin
      pc_nxt_s    = redirect_pc;
      state_nxt_s = fetch_en ? FETCH : IDLE;
      fault_nxt_s = 1'b0;
    end else begin
      pc_nxt_s = push_s ? (pc_r + 32'd4) : pc_r;
      case (state_r)
        IDLE: begin
          state_nxt_s = fetch_en ? FETCH : IDLE;
        end
        FETCH: begin
          if (!fetch_en) begin
            state_nxt_s = IDLE;
          end else if (pc_bad_s) begin
            state_nxt_s    = FAULT;
            fault_nxt_s    = 1'b1;
            fault_pc_nxt_s = pc_r;
          end else begin
            state_nxt_s = FETCH;
          end
        end
        FAULT: begin
          state_nxt_s = FAULT;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State, PC, fault and FIFO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      count_r    <= {CNT_W{1'b0}};
      fault_r    <= 1'b0;
      fault_pc_r <= 32'h0000_0000;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_r[i]    <= 32'h0000_0000;
        fifo_instr_r[i] <= 32'h0000_0000;
      end
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      count_r    <= count_nxt_s;
      fault_r    <= fault_nxt_s;
      fault_pc_r <= fault_pc_nxt_s;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_r[i]    <= fifo_pc_nxt_s[i];
        fifo_instr_r[i] <= fifo_instr_nxt_s[i];
      end
    end
  end

  assign imem_req    = push_s;
  assign imem_addr   = pc_r;
  assign if_valid    = if_valid_s;
  assign if_instr    = fifo_instr_r[0];
  assign if_pc       = fifo_pc_r[0];
  assign fetch_fault = fault_r;
  assign fault_pc    = fault_pc_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_FAULT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  logic [31:0] mem [32];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[6:2]];

  instruction_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .MEM_BYTES (128),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .fetch_fault   (fetch_fault),
    .fault_pc      (fault_pc)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, if_valid, fetch_fault, if_instr, if_pc, fault_pc, imem_addr} !==
        {1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, RESET_PC})
      $display("FAIL reset_values: got req=%b v=%b f=%b instr=%h pc=%h fpc=%h addr=%h want all 0",
               imem_req, if_valid, fetch_fault, if_instr, if_pc, fault_pc, imem_addr);
    else n_pass++;
    cyc();
    rst_n = 1'b1;
    cyc();
    #1;
    n_checks++;
    if ({imem_req, if_valid} !== 2'b00)
      $display("FAIL reset_idle: got req=%b v=%b want 0 0", imem_req, if_valid);
    else n_pass++;
  endtask

  task automatic test_streaming();
    logic [31:0] words [3];
    words[0] = 32'h0050_0093;
    words[1] = 32'h0010_0113;
    words[2] = 32'h0020_81B3;
    do_reset();
    fetch_en = 1'b1;
    if_ready = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL stream_idle_req: got %b want 0", imem_req);
    else n_pass++;
    cyc();
    #1;
    n_checks++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h0, 1'b0})
      $display("FAIL stream_first: got req=%b addr=%h v=%b want 1 0 0", imem_req, imem_addr, if_valid);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      n_checks++;
      if ({imem_req, imem_addr, if_valid, if_pc, if_instr} !==
          {1'b1, 32'(4 * (k + 1)), 1'b1, 32'(4 * k), words[k]})
        $display("FAIL stream_%0d: got req=%b addr=%h v=%b pc=%h instr=%h want 1 %h 1 %h %h",
                 k, imem_req, imem_addr, if_valid, if_pc, if_instr, 32'(4 * (k + 1)), 32'(4 * k), words[k]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int pushes = 0;
    int pops = 0;
    logic [31:0] exp_pc = 32'h0;
    do_reset();
    fetch_en = 1'b1;
    if_ready = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      if (imem_req === 1'b1) pushes++;
      cyc();
    end
    #1;
    n_checks++;
    if (pushes != 2) $display("FAIL bp_pushes: got %0d want 2", pushes);
    else n_pass++;
    n_checks++;
    if ({imem_req, if_valid, if_instr, if_pc} !== {1'b0, 1'b1, 32'h0050_0093, 32'h0})
      $display("FAIL bp_hold: got req=%b v=%b instr=%h pc=%h want 0 1 00500093 0",
               imem_req, if_valid, if_instr, if_pc);
    else n_pass++;
    if_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (if_valid === 1'b1) begin
        pops++;
        n_checks++;
        if ({if_pc, if_instr} !== {exp_pc, mem[exp_pc[6:2]]})
          $display("FAIL bp_resume: got pc=%h instr=%h want %h %h", if_pc, if_instr, exp_pc, mem[exp_pc[6:2]]);
        else n_pass++;
        exp_pc = exp_pc + 32'd4;
      end
      cyc();
    end
    n_checks++;
    if (pops != 6) $display("FAIL bp_pop_count: got %0d want 6", pops);
    else n_pass++;
  endtask

  task automatic test_redirect();
    do_reset();
    fetch_en = 1'b1;
    if_ready = 1'b0;
    cyc();
    cyc();
    cyc();
    #1;
    n_checks++;
    if ({if_valid, imem_req} !== 2'b10)
      $display("FAIL redir_full: got v=%b req=%b want 1 0", if_valid, imem_req);
    else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    if_ready       = 1'b1;
    #1;
    n_checks++;
    if ({if_valid, imem_req} !== 2'b00)
      $display("FAIL redir_cycle: got v=%b req=%b want 0 0", if_valid, imem_req);
    else n_pass++;
    cyc();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h40, 1'b0})
      $display("FAIL redir_req: got req=%b addr=%h v=%b want 1 40 0", imem_req, imem_addr, if_valid);
    else n_pass++;
    cyc();
    #1;
    n_checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h40, mem[16]})
      $display("FAIL redir_head: got v=%b pc=%h instr=%h want 1 40 %h", if_valid, if_pc, if_instr, mem[16]);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h22;
    #1;
    cyc();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, fetch_fault} !== 2'b00)
      $display("FAIL mis_n1: got req=%b fault=%b want 0 0", imem_req, fetch_fault);
    else n_pass++;
    cyc();
    #1;
    n_checks++;
    if ({imem_req, fetch_fault, fault_pc, if_valid} !== {1'b0, 1'b1, 32'h22, 1'b0})
      $display("FAIL mis_fault: got req=%b fault=%b fpc=%h v=%b want 0 1 22 0",
               imem_req, fetch_fault, fault_pc, if_valid);
    else n_pass++;
    cyc();
    cyc();
    #1;
    n_checks++;
    if ({imem_req, fetch_fault} !== 2'b01)
      $display("FAIL mis_hold: got req=%b fault=%b want 0 1", imem_req, fetch_fault);
    else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    #1;
    cyc();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if ({fetch_fault, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h10})
      $display("FAIL mis_recover: got fault=%b req=%b addr=%h want 0 1 10", fetch_fault, imem_req, imem_addr);
    else n_pass++;
    cyc();
    #1;
    n_checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h10, mem[4]})
      $display("FAIL mis_head: got v=%b pc=%h instr=%h want 1 10 %h", if_valid, if_pc, if_instr, mem[4]);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    fetch_en       = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h74;
    #1;
    cyc();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'(32'h74 + 4 * k)})
        $display("FAIL oor_req_%0d: got req=%b addr=%h want 1 %h", k, imem_req, imem_addr, 32'(32'h74 + 4 * k));
      else n_pass++;
      cyc();
    end
    if_ready = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, fetch_fault, if_valid, if_pc, if_instr} !== {1'b0, 1'b0, 1'b1, 32'h7C, mem[31]})
      $display("FAIL oor_stop: got req=%b fault=%b v=%b pc=%h instr=%h want 0 0 1 7c %h",
               imem_req, fetch_fault, if_valid, if_pc, if_instr, mem[31]);
    else n_pass++;
    cyc();
    #1;
    n_checks++;
    if ({fetch_fault, fault_pc, imem_req, if_valid, if_pc} !== {1'b1, 32'h80, 1'b0, 1'b1, 32'h7C})
      $display("FAIL oor_fault: got fault=%b fpc=%h req=%b v=%b pc=%h want 1 80 0 1 7c",
               fetch_fault, fault_pc, imem_req, if_valid, if_pc);
    else n_pass++;
    if_ready = 1'b1;
    #1;
    cyc();
    #1;
    n_checks++;
    if ({if_valid, imem_req, fetch_fault} !== 3'b001)
      $display("FAIL oor_drained: got v=%b req=%b fault=%b want 0 0 1", if_valid, imem_req, fetch_fault);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    fetch_en = 1'b1;
    if_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    #1;
    n_checks++;
    if ({imem_req, if_valid} !== 2'b11)
      $display("FAIL arst_pre: got req=%b v=%b want 1 1", imem_req, if_valid);
    else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, if_valid, fetch_fault, imem_addr} !== {1'b0, 1'b0, 1'b0, RESET_PC})
      $display("FAIL arst_now: got req=%b v=%b fault=%b addr=%h want 0 0 0 %h",
               imem_req, if_valid, fetch_fault, imem_addr, RESET_PC);
    else n_pass++;
    cyc();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL arst_idle: got req=%b want 0", imem_req);
    else n_pass++;
    cyc();
    #1;
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, RESET_PC})
      $display("FAIL arst_first: got req=%b addr=%h want 1 %h", imem_req, imem_addr, RESET_PC);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] q_pc [$];
    logic [31:0] q_in [$];
    logic [31:0] m_pc;
    logic [31:0] m_fpc;
    logic        m_fault;
    int          m_mode;
    bit          e_valid, e_pop, e_req, bad;
    int          sel;
    do_reset();
    m_pc    = RESET_PC;
    m_fpc   = 32'h0;
    m_fault = 1'b0;
    m_mode  = M_IDLE;
    for (int c = 0; c < 600; c++) begin
      fetch_en       = ($urandom_range(0, 9) != 0);
      if_ready       = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      sel = $urandom_range(0, 9);
      if (sel == 0)      redirect_pc = 32'($urandom_range(0, 127));
      else if (sel == 1) redirect_pc = 32'h78 + 32'(4 * $urandom_range(0, 3));
      else               redirect_pc = 32'(4 * $urandom_range(0, 31));
      #1;
      // reference: spec rules evaluated on queue occupancy
      e_valid = (q_pc.size() != 0) && !redirect_valid;
      e_pop   = e_valid && if_ready;
      bad     = (m_pc[1:0] != 2'b00) || (({32'h0, m_pc} + 64'd3) >= 64'd128);
      e_req   = (m_mode == M_FETCH) && fetch_en && !redirect_valid && !bad &&
                ((q_pc.size() < 2) || e_pop);
      n_checks++;
      if ({imem_req, imem_addr, if_valid} !== {e_req, m_pc, e_valid})
        $display("FAIL rnd_req c=%0d: got req=%b addr=%h v=%b want %b %h %b",
                 c, imem_req, imem_addr, if_valid, e_req, m_pc, e_valid);
      else n_pass++;
      if (e_valid) begin
        n_checks++;
        if ({if_pc, if_instr} !== {q_pc[0], q_in[0]})
          $display("FAIL rnd_head c=%0d: got pc=%h instr=%h want %h %h", c, if_pc, if_instr, q_pc[0], q_in[0]);
        else n_pass++;
      end
      n_checks++;
      if ({fetch_fault, fault_pc} !== {m_fault, m_fpc})
        $display("FAIL rnd_fault c=%0d: got f=%b fpc=%h want %b %h", c, fetch_fault, fault_pc, m_fault, m_fpc);
      else n_pass++;
      if (redirect_valid) begin
        q_pc.delete();
        q_in.delete();
        m_pc    = redirect_pc;
        m_mode  = fetch_en ? M_FETCH : M_IDLE;
        m_fault = 1'b0;
      end else begin
        if (e_pop) begin
          void'(q_pc.pop_front());
          void'(q_in.pop_front());
        end
        if (e_req) begin
          q_pc.push_back(m_pc);
          q_in.push_back(mem[m_pc[6:2]]);
          m_pc = m_pc + 32'd4;
        end
        if (m_mode == M_IDLE && fetch_en) m_mode = M_FETCH;
        else if (m_mode == M_FETCH && !fetch_en) m_mode = M_IDLE;
        else if (m_mode == M_FETCH && bad) begin
          m_mode  = M_FAULT;
          m_fault = 1'b1;
          m_fpc   = m_pc;
        end
      end
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;
    mem[2] = 32'h0020_81B3;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_out_of_range();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
